// File: rtl/tile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_pkg                                                                   |
// | Shared geometry, cell format and palette for the tile renderer.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tile_pkg;

    localparam int CELL_LOG2 = 4;
    localparam int COLS      = 40;
    localparam int ROWS      = 30;
    localparam int ADDR_W    = 11;

    typedef struct packed {
        logic       outline;
        logic [2:0] color_idx;
    } cell_t;

    typedef enum logic [0:0] {
        SW_IDLE    = 1'b0,
        SW_PENDING = 1'b1
    } swap_state_t;

    // {r[1:0], g[1:0], b[1:0]}
    localparam logic [5:0] PALETTE [8] = '{
        6'b000000,  // black
        6'b110000,  // red
        6'b001100,  // green
        6'b000011,  // blue
        6'b111100,  // yellow
        6'b001111,  // cyan
        6'b110011,  // magenta
        6'b111111   // white
    };

    localparam logic [5:0] OUTLINE_RGB = 6'b111111;

endpackage
`default_nettype wire

// File: rtl/tile_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_ram                                                                   |
// | Simple dual-port cell RAM, one write port and one registered read port.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tile_ram #(
    parameter int DEPTH = 1200,
    parameter int AW    = 11,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // No reset on storage or read data so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < AW'(DEPTH))) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_raddr < AW'(DEPTH)) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_renderer                                                              |
// | Three-stage cell-to-pixel pipeline with double-buffered board and          |
// | vblank-synchronised buffer swap.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tile_renderer #(
    parameter int CELL_LOG2  = tile_pkg::CELL_LOG2,
    parameter int COLS       = tile_pkg::COLS,
    parameter int ROWS       = tile_pkg::ROWS,
    parameter int VBLANK_ROW = 480,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  col,
    input  logic [9:0]  row,
    input  logic        visible,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        swap_done,
    output logic [5:0]  rgb,
    output logic        hsync,
    output logic        vsync
);

    import tile_pkg::*;

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = ADDR_W;

    logic [AW-1:0]      w_row_base;
    logic [AW-1:0]      w_rd_addr;
    logic               w_edge;
    logic               w_commit;
    logic               w_wr_ok;
    logic [3:0]         w_rd0;
    logic [3:0]         w_rd1;
    cell_t              w_cell;

    logic [AW-1:0]      r_s1_addr;
    logic               r_s1_edge;
    logic               r_s1_vis;
    logic               r_s2_edge;
    logic               r_s2_vis;
    logic               r_s2_front;
    logic [5:0]         r_rgb;
    logic [LATENCY-1:0] r_hs_dly;
    logic [LATENCY-1:0] r_vs_dly;

    swap_state_t        r_state;
    logic               r_front;
    logic               r_swap_pending;
    logic               r_swap_done;

    // Row base = cell_row * COLS; shift-add form keeps the x40 off DSP blocks.
    generate
        if (COLS == 40) begin : g_mul40
            logic [AW-1:0] w_r;
            assign w_r        = AW'(row[9:CELL_LOG2]);
            assign w_row_base = (w_r << 5) + (w_r << 3);
        end else begin : g_mul_generic
            assign w_row_base = AW'(row[9:CELL_LOG2]) * AW'(COLS);
        end
    endgenerate

    assign w_rd_addr = w_row_base + AW'(col[9:CELL_LOG2]);
    assign w_edge    = (col[CELL_LOG2-1:0] == '0) || (col[CELL_LOG2-1:0] == '1) ||
                       (row[CELL_LOG2-1:0] == '0) || (row[CELL_LOG2-1:0] == '1);
    assign w_commit  = (row == 10'(VBLANK_ROW)) && (col == 10'd0);
    assign w_wr_ok   = wr_en && (wr_addr < AW'(DEPTH));

    // Writes always go to the buffer that is not being displayed.
    tile_ram #(.DEPTH(DEPTH), .AW(AW), .DW(4)) u_ram0 (
        .clk     (clk),
        .i_we    (w_wr_ok && r_front),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_s1_addr),
        .o_rdata (w_rd0)
    );

    tile_ram #(.DEPTH(DEPTH), .AW(AW), .DW(4)) u_ram1 (
        .clk     (clk),
        .i_we    (w_wr_ok && !r_front),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_s1_addr),
        .o_rdata (w_rd1)
    );

    assign w_cell = cell_t'(r_s2_front ? w_rd1 : w_rd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_addr  <= '0;
            r_s1_edge  <= 1'b0;
            r_s1_vis   <= 1'b0;
            r_s2_edge  <= 1'b0;
            r_s2_vis   <= 1'b0;
            r_s2_front <= 1'b0;
            r_rgb      <= '0;
            r_hs_dly   <= '1;
            r_vs_dly   <= '1;
        end else begin
            r_s1_addr  <= w_rd_addr;
            r_s1_edge  <= w_edge;
            r_s1_vis   <= visible;
            r_s2_edge  <= r_s1_edge;
            r_s2_vis   <= r_s1_vis;
            r_s2_front <= r_front;
            if (!r_s2_vis) begin
                r_rgb <= '0;
            end else if (w_cell.outline && r_s2_edge) begin
                r_rgb <= OUTLINE_RGB;
            end else begin
                r_rgb <= PALETTE[w_cell.color_idx];
            end
            r_hs_dly <= {r_hs_dly[LATENCY-2:0], hsync_in};
            r_vs_dly <= {r_vs_dly[LATENCY-2:0], vsync_in};
        end
    end

    // A request coinciding with the commit event is committed immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= SW_IDLE;
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                SW_IDLE: begin
                    if (swap_req) begin
                        if (w_commit) begin
                            r_front     <= ~r_front;
                            r_swap_done <= 1'b1;
                        end else begin
                            r_state        <= SW_PENDING;
                            r_swap_pending <= 1'b1;
                        end
                    end
                end
                SW_PENDING: begin
                    if (w_commit) begin
                        r_state        <= SW_IDLE;
                        r_swap_pending <= 1'b0;
                        r_front        <= ~r_front;
                        r_swap_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= SW_IDLE;
                    r_swap_pending <= 1'b0;
                end
            endcase
        end
    end

    assign rgb          = r_rgb;
    assign hsync        = r_hs_dly[LATENCY-1];
    assign vsync        = r_vs_dly[LATENCY-1];
    assign swap_pending = r_swap_pending;
    assign swap_done    = r_swap_done;

endmodule
`default_nettype wire

// File: tb/tb_tile_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tile_renderer                                                           |
// | Directed self-checking bench for tile_renderer.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tile_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        visible;
    logic        hsync_in;
    logic        vsync_in;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [3:0]  wr_data;
    logic        swap_req;
    logic        swap_pending;
    logic        swap_done;
    logic [5:0]  rgb;
    logic        hsync;
    logic        vsync;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tile_renderer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col          (col),
        .row          (row),
        .visible      (visible),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .rgb          (rgb),
        .hsync        (hsync),
        .vsync        (vsync)
    );

    task automatic set_idle();
        col      = 10'd700;
        row      = 10'd500;
        visible  = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        wr_en    = 1'b0;
        swap_req = 1'b0;
    endtask

    // Presents one pixel and returns on the negedge where its rgb is on the pins.
    task automatic show_pixel(input int c, input int r, input logic vis);
        @(negedge clk);
        set_idle();
        col     = 10'(c);
        row     = 10'(r);
        visible = vis;
        @(negedge clk);
        set_idle();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic write_cell(input int a, input logic [3:0] d);
        @(negedge clk);
        set_idle();
        wr_en   = 1'b1;
        wr_addr = 11'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clear_back();
        for (int a = 0; a < 1200; a++) begin
            @(negedge clk);
            set_idle();
            wr_en   = 1'b1;
            wr_addr = 11'(a);
            wr_data = 4'h0;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_swap();
        @(negedge clk);
        set_idle();
        row      = 10'd100;
        col      = 10'd5;
        swap_req = 1'b1;
        @(negedge clk);
        set_idle();
        row = 10'd480;
        col = 10'd0;
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        set_idle();
        wr_addr = '0;
        wr_data = '0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            col      = (i == 2) ? 10'd0 : 10'(i * 17);
            row      = (i == 2) ? 10'd480 : 10'(i * 19);
            visible  = 1'b1;
            hsync_in = i[0];
            vsync_in = ~i[0];
            swap_req = 1'b1;
            #1;
            n_checks++;
            if ({rgb, hsync, vsync, swap_pending, swap_done} !== {6'b0, 1'b1, 1'b1, 1'b0, 1'b0})
                $display("FAIL reset_outputs[%0d]: got rgb=%b hs=%b vs=%b pend=%b done=%b expected 000000 1 1 0 0",
                         i, rgb, hsync, vsync, swap_pending, swap_done);
            else
                n_pass++;
        end
        @(negedge clk);
        set_idle();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_latency();
        logic exp_hs;
        for (int j = 0; j < 803; j++) begin
            @(negedge clk);
            exp_hs = !((j - 3) >= 656 && (j - 3) <= 751);
            n_checks++;
            if ({hsync, vsync} !== {exp_hs, 1'b1})
                $display("FAIL sync_latency[%0d]: got hs=%b vs=%b expected hs=%b vs=1", j, hsync, vsync, exp_hs);
            else
                n_pass++;
            if (j - 3 >= 640) begin
                n_checks++;
                if (rgb !== 6'b0)
                    $display("FAIL blank_rgb[%0d]: got %b expected 000000", j, rgb);
                else
                    n_pass++;
            end
            set_idle();
            if (j < 800) begin
                row      = 10'd0;
                col      = 10'(j);
                visible  = (j < 640);
                hsync_in = !(j >= 656 && j <= 751);
            end
        end
    endtask

    task automatic test_color();
        clear_back();
        do_swap();
        clear_back();
        do_swap();
        write_cell(41, 4'b1001);
        write_cell(43, 4'b0110);
        do_swap();
        show_pixel(16, 16, 1'b1);
        n_checks++;
        if (rgb !== 6'b111111) $display("FAIL outline_edge: got %b expected 111111", rgb); else n_pass++;
        show_pixel(31, 31, 1'b1);
        n_checks++;
        if (rgb !== 6'b111111) $display("FAIL outline_far_edge: got %b expected 111111", rgb); else n_pass++;
        show_pixel(24, 24, 1'b1);
        n_checks++;
        if (rgb !== 6'b110000) $display("FAIL red_interior: got %b expected 110000", rgb); else n_pass++;
        show_pixel(40, 24, 1'b1);
        n_checks++;
        if (rgb !== 6'b000000) $display("FAIL unwritten_cell: got %b expected 000000", rgb); else n_pass++;
        show_pixel(48, 16, 1'b1);
        n_checks++;
        if (rgb !== 6'b110011) $display("FAIL edge_no_outline: got %b expected 110011", rgb); else n_pass++;
        show_pixel(24, 24, 1'b0);
        n_checks++;
        if (rgb !== 6'b000000) $display("FAIL invisible_blanked: got %b expected 000000", rgb); else n_pass++;
    endtask

    task automatic test_swap_timing();
        write_cell(0, 4'b0100);
        @(negedge clk);
        set_idle();
        row      = 10'd100;
        col      = 10'd5;
        swap_req = 1'b1;
        @(negedge clk);
        set_idle();
        row = 10'd101;
        n_checks++;
        if ({swap_pending, swap_done} !== 2'b10)
            $display("FAIL pending_after_req: got pend=%b done=%b expected 1 0", swap_pending, swap_done);
        else
            n_pass++;
        show_pixel(8, 8, 1'b1);
        n_checks++;
        if (rgb !== 6'b000000) $display("FAIL old_buffer_before_vblank: got %b expected 000000", rgb); else n_pass++;
        @(negedge clk);
        set_idle();
        row = 10'd479;
        col = 10'd799;
        @(negedge clk);
        n_checks++;
        if ({swap_pending, swap_done} !== 2'b10)
            $display("FAIL pending_before_commit: got pend=%b done=%b expected 1 0", swap_pending, swap_done);
        else
            n_pass++;
        set_idle();
        row     = 10'd480;
        col     = 10'd0;
        wr_en   = 1'b1;
        wr_addr = 11'd2;
        wr_data = 4'b0111;
        @(negedge clk);
        set_idle();
        n_checks++;
        if ({swap_pending, swap_done} !== 2'b01)
            $display("FAIL commit_pulse: got pend=%b done=%b expected 0 1", swap_pending, swap_done);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if (swap_done !== 1'b0) $display("FAIL pulse_one_cycle: got %b expected 0", swap_done); else n_pass++;
        show_pixel(8, 8, 1'b1);
        n_checks++;
        if (rgb !== 6'b111100) $display("FAIL new_front: got %b expected 111100", rgb); else n_pass++;
        show_pixel(40, 8, 1'b1);
        n_checks++;
        if (rgb !== 6'b111111) $display("FAIL commit_cycle_write: got %b expected 111111", rgb); else n_pass++;

        @(negedge clk);
        set_idle();
        row      = 10'd480;
        col      = 10'd0;
        swap_req = 1'b1;
        @(negedge clk);
        set_idle();
        n_checks++;
        if ({swap_pending, swap_done} !== 2'b01)
            $display("FAIL same_cycle_commit: got pend=%b done=%b expected 0 1", swap_pending, swap_done);
        else
            n_pass++;
        show_pixel(8, 8, 1'b1);
        n_checks++;
        if (rgb !== 6'b000000) $display("FAIL same_cycle_front: got %b expected 000000", rgb); else n_pass++;
    endtask

    task automatic test_double_req();
        int n_done = 0;
        @(negedge clk);
        set_idle();
        row      = 10'd100;
        swap_req = 1'b1;
        @(negedge clk);
        n_done += int'(swap_done);
        set_idle();
        row      = 10'd101;
        swap_req = 1'b1;
        @(negedge clk);
        n_done += int'(swap_done);
        set_idle();
        row = 10'd480;
        col = 10'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_done += int'(swap_done);
            set_idle();
        end
        n_checks++;
        if (n_done != 1) $display("FAIL double_req_pulses: got %0d expected 1", n_done); else n_pass++;
        show_pixel(8, 8, 1'b1);
        n_checks++;
        if (rgb !== 6'b111100) $display("FAIL double_req_front: got %b expected 111100", rgb); else n_pass++;
    endtask

    task automatic test_out_of_range();
        write_cell(1200, 4'hF);
        write_cell(2047, 4'hF);
        write_cell(1199, 4'b0011);
        do_swap();
        show_pixel(630, 470, 1'b1);
        n_checks++;
        if (rgb !== 6'b000011) $display("FAIL last_cell: got %b expected 000011", rgb); else n_pass++;
        show_pixel(639, 479, 1'b1);
        n_checks++;
        if (rgb !== 6'b000011) $display("FAIL last_cell_corner: got %b expected 000011", rgb); else n_pass++;
        show_pixel(8, 8, 1'b1);
        n_checks++;
        if (rgb !== 6'b000000) $display("FAIL cell0_untouched: got %b expected 000000", rgb); else n_pass++;
        show_pixel(24, 24, 1'b1);
        n_checks++;
        if (rgb !== 6'b110000) $display("FAIL cell41_untouched: got %b expected 110000", rgb); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        @(negedge clk);
        set_idle();
        row      = 10'd300;
        col      = 10'd5;
        swap_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_idle();
            col      = 10'd24;
            row      = 10'd24;
            visible  = 1'b1;
            hsync_in = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({rgb, hsync, swap_pending} !== {6'b110000, 1'b0, 1'b1})
            $display("FAIL before_mid_reset: got rgb=%b hs=%b pend=%b expected 110000 0 1", rgb, hsync, swap_pending);
        else
            n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rgb, hsync, vsync, swap_pending} !== {6'b0, 1'b1, 1'b1, 1'b0})
            $display("FAIL async_reset_mid: got rgb=%b hs=%b vs=%b pend=%b expected 000000 1 1 0",
                     rgb, hsync, vsync, swap_pending);
        else
            n_pass++;
        @(negedge clk);
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_idle();
        row = 10'd480;
        col = 10'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_done += int'(swap_done);
            set_idle();
        end
        n_checks++;
        if (n_done != 0) $display("FAIL lost_swap_no_done: got %0d expected 0", n_done); else n_pass++;
        show_pixel(8, 8, 1'b1);
        n_checks++;
        if (rgb !== 6'b111100) $display("FAIL front_after_reset: got %b expected 111100", rgb); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_color();
        test_swap_timing();
        test_double_req();
        test_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
